// File: rtl/mult_arb_if.sv
// Requester-side bus of mult_arb: flat operand buses in, one-hot grant and result strobe out.
interface mult_arb_if #(
    parameter int unsigned WIDT_A = 8,
    parameter int unsigned WIDT_B = 8,
    parameter int unsigned N_REQ  = 4
);
    logic [N_REQ-1:0]        REQ_VALID;
    logic [N_REQ*WIDT_A-1:0] REQ_A;
    logic [N_REQ*WIDT_B-1:0] REQ_B;
    logic [N_REQ-1:0]        REQ_READY;
    logic [N_REQ-1:0]        RES_VALID;
    logic [WIDT_A+WIDT_B-1:0] RES_P;
    logic [15:0]             STALL_CNT;

    modport master (
        output REQ_VALID, REQ_A, REQ_B,
        input  REQ_READY, RES_VALID, RES_P, STALL_CNT
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B,
        output REQ_READY, RES_VALID, RES_P, STALL_CNT
    );
endinterface

// File: rtl/mult_arb.sv
// Round-robin arbiter in front of one shared two-stage unsigned multiplier.
// Optional contention counter enabled by defining MULT_ARB_STALL_CNT_EN.
module mult_arb #(
    parameter int unsigned WIDT_A = 8,
    parameter int unsigned WIDT_B = 8,
    parameter int unsigned N_REQ  = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    mult_arb_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned PW   = WIDT_A + WIDT_B;

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   win_idx;
    logic              found;
    int unsigned       cand;
    logic [N_REQ-1:0]  grant;
    logic              accept;
    logic [WIDT_A-1:0] sel_a;
    logic [WIDT_B-1:0] sel_b;

    logic              v1_q;
    logic [WIDT_A-1:0] a1_q;
    logic [WIDT_B-1:0] b1_q;
    logic [N_REQ-1:0]  tag1_q;

    logic [PW-1:0]     prod;
    logic [PW-1:0]     res_p_q;
    logic [N_REQ-1:0]  res_valid_q;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        cand    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(ptr_q) + k) % N_REQ;
            if (!found && bus.REQ_VALID[cand]) begin
                found   = 1'b1;
                win_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found && RSTN) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign accept        = |grant;
    assign bus.REQ_READY = grant;
    assign sel_a         = bus.REQ_A[32'(win_idx)*WIDT_A +: WIDT_A];
    assign sel_b         = bus.REQ_B[32'(win_idx)*WIDT_B +: WIDT_B];
    assign ptr_d         = accept ? win_idx : ptr_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr_q <= IdxW'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Stage 1: capture the winner's operands and its one-hot tag.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            tag1_q <= '0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                a1_q   <= sel_a;
                b1_q   <= sel_b;
                tag1_q <= grant;
            end
        end
    end

    assign prod = PW'(a1_q) * PW'(b1_q);

    // Stage 2: product only updates with a valid operation so RES_P holds between strobes.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            res_p_q     <= '0;
            res_valid_q <= '0;
        end else begin
            res_valid_q <= v1_q ? tag1_q : '0;
            if (v1_q) begin
                res_p_q <= prod;
            end
        end
    end

    assign bus.RES_P     = res_p_q;
    assign bus.RES_VALID = res_valid_q;

`ifdef MULT_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic        stall;

    assign stall = |(bus.REQ_VALID & ~grant);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.STALL_CNT = stall_cnt_q;
`else
    assign bus.STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb: reset, single op, round-robin, back-to-back, wrap, mid-op reset.
module tb_mult_arb;

    logic CLK;
    logic RSTN;
    int   n_chk;
    int   n_bad;
    int   stall_on;

    mult_arb_if bus ();

    mult_arb u_dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.REQ_A[i*8 +: 8] = a;
        bus.REQ_B[i*8 +: 8] = b;
    endtask

    task automatic pulse_reset();
        RSTN = 1'b0;
        #2;
        RSTN = 1'b1;
    endtask

    logic [15:0] exp30 [4];
    logic [15:0] exp31 [5];

    initial begin
        n_chk = 0;
        n_bad = 0;
`ifdef MULT_ARB_STALL_CNT_EN
        stall_on = 1;
`else
        stall_on = 0;
`endif
        exp30 = '{16'd6, 16'd12, 16'd20, 16'd30};
        exp31 = '{16'd1, 16'd4, 16'd9, 16'd16, 16'd25};

        RSTN          = 1'b0;
        bus.REQ_A     = '0;
        bus.REQ_B     = '0;
        bus.REQ_VALID = 4'b1111;
        #1;
        check_eq("rst_ready", 32'(bus.REQ_READY), 0);
        check_eq("rst_res_valid", 32'(bus.RES_VALID), 0);
        check_eq("rst_res_p", 32'(bus.RES_P), 0);
        check_eq("rst_stall", 32'(bus.STALL_CNT), 0);
        bus.REQ_VALID = '0;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;

        // Single operation from requester 0
        set_lane(0, 8'd200, 8'd255);
        bus.REQ_VALID = 4'b0001;
        #1;
        check_eq("t29_ready", 32'(bus.REQ_READY), 1);
        tick();
        bus.REQ_VALID = '0;
        check_eq("t29_stage1", 32'(bus.RES_VALID), 0);
        tick();
        check_eq("t29_res_valid", 32'(bus.RES_VALID), 1);
        check_eq("t29_res_p", 32'(bus.RES_P), 51000);
        tick();
        check_eq("t29_strobe_end", 32'(bus.RES_VALID), 0);
        check_eq("t29_hold_p", 32'(bus.RES_P), 51000);

        // All four requesting: strict rotation
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 8'(i + 2), 8'(i + 3));
        end
        bus.REQ_VALID = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) bus.REQ_VALID = '0;
            #1;
            if (c < 8) check_eq("t30_grant", 32'(bus.REQ_READY), 32'(1) << (c % 4));
            if (c >= 2) begin
                check_eq("t30_res_tag", 32'(bus.RES_VALID), 32'(1) << ((c - 2) % 4));
                check_eq("t30_res_p", 32'(bus.RES_P), 32'(exp30[(c - 2) % 4]));
            end
            if (c == 4) check_eq("t30_stall4", 32'(bus.STALL_CNT), 32'(4 * stall_on));
            if (c >= 8) check_eq("t30_stall8", 32'(bus.STALL_CNT), 32'(8 * stall_on));
            tick();
        end

        // Sole requester 2, back-to-back
        bus.REQ_VALID = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            if (c < 5) set_lane(2, 8'(c + 1), 8'(c + 1));
            else bus.REQ_VALID = '0;
            #1;
            if (c < 5) check_eq("t31_grant", 32'(bus.REQ_READY), 4);
            if (c >= 2) begin
                check_eq("t31_res_tag", 32'(bus.RES_VALID), 4);
                check_eq("t31_res_p", 32'(bus.RES_P), 32'(exp31[c - 2]));
            end
            tick();
        end

        // Wrap-around from requester 3 to requester 0
        set_lane(0, 8'd10, 8'd11);
        set_lane(3, 8'd12, 8'd13);
        bus.REQ_VALID = 4'b1000;
        #1;
        check_eq("t32_grant3", 32'(bus.REQ_READY), 8);
        tick();
        bus.REQ_VALID = 4'b1001;
        #1;
        check_eq("t32_wrap", 32'(bus.REQ_READY), 1);
        tick();
        #1;
        check_eq("t32_next", 32'(bus.REQ_READY), 8);
        check_eq("t32_res_tag_a", 32'(bus.RES_VALID), 8);
        check_eq("t32_res_p_a", 32'(bus.RES_P), 156);
        tick();
        bus.REQ_VALID = '0;
        check_eq("t32_res_tag_b", 32'(bus.RES_VALID), 1);
        check_eq("t32_res_p_b", 32'(bus.RES_P), 110);
        tick();
        check_eq("t32_res_tag_c", 32'(bus.RES_VALID), 8);
        check_eq("t32_res_p_c", 32'(bus.RES_P), 156);

        // Reset right after an accept discards it
        set_lane(1, 8'd7, 8'd9);
        bus.REQ_VALID = 4'b0010;
        #1;
        check_eq("t33_grant", 32'(bus.REQ_READY), 2);
        tick();
        bus.REQ_VALID = '0;
        RSTN = 1'b0;
        #1;
        check_eq("t33_rst_valid", 32'(bus.RES_VALID), 0);
        check_eq("t33_rst_p", 32'(bus.RES_P), 0);
        RSTN = 1'b1;
        tick();
        check_eq("t33_no_res", 32'(bus.RES_VALID), 0);
        check_eq("t33_p_zero", 32'(bus.RES_P), 0);
        bus.REQ_VALID = 4'b1111;
        #1;
        check_eq("t33_ptr0", 32'(bus.REQ_READY), 1);
        tick();
        bus.REQ_VALID = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 The block SHALL have parameter WIDT_A, default 8, meaning operand A width in bits.
REQ-002 The block SHALL have parameter WIDT_B, default 8, meaning operand B width in bits.
REQ-003 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing the multiplier (legal range 2..8).
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port RSTN, input, 1, the reset: asynchronous and active-low.
REQ-006 The block SHALL have port REQ_VALID, input, N_REQ, with bit i set when requester i presents an operand pair.
REQ-007 The block SHALL have port REQ_A, input, N_REQ*WIDT_A, carrying the flat operand A buses; requester i occupies bits [i*WIDT_A +: WIDT_A].
REQ-008 The block SHALL have port REQ_B, input, N_REQ*WIDT_B, carrying the flat operand B buses, packed in the same way as REQ_A.
REQ-009 The block SHALL have port REQ_READY, output, N_REQ, a one-hot grant; requester i's operands are accepted when REQ_VALID[i] and REQ_READY[i] are both 1 in the same cycle.
REQ-010 The block SHALL have port RES_VALID, output, N_REQ, a one-hot result strobe naming the owner of RES_P.
REQ-011 The block SHALL have port RES_P, output, WIDT_A+WIDT_B, carrying the unsigned product.
REQ-012 The block SHALL have port STALL_CNT, output, 16, a contention statistic (see Configuration).

Function
REQ-013 The block SHALL contain exactly one unsigned multiplier, shared by all requesters.
REQ-014 REQ_READY SHALL be combinational from REQ_VALID and the priority pointer, with at most one bit set, and only for a requester whose REQ_VALID is 1.
REQ-015 Arbitration SHALL be round-robin: the search starts at requester (PTR+1) mod N_REQ and proceeds upward with wrap-around; the first requester found with REQ_VALID set wins.
REQ-016 PTR SHALL load the winner index on every cycle with a grant; it SHALL hold when no requester is valid.
REQ-017 Stage 1: on a grant, the winner's A, B and a one-hot tag SHALL register at the next edge, with stage-1 valid set; with no grant, stage-1 valid SHALL clear.
REQ-018 Stage 2: RES_P SHALL register A*B (full width, no truncation), and RES_VALID SHALL register the stage-1 tag gated by stage-1 valid.
REQ-019 Latency SHALL be fixed: RES_VALID[i] is high exactly 2 cycles after the accepting edge, for 1 cycle.
REQ-020 Throughput SHALL be one accept per cycle with no bubble between back-to-back grants, including repeated grants to the same requester when it is the only one valid.
REQ-021 The result path SHALL have no backpressure; requesters must capture the result on the strobe.
REQ-022 RES_P SHALL hold its last value while RES_VALID is 0.
REQ-023 A requester that drops REQ_VALID without being granted SHALL lose its request, with no side effects.

Reset
REQ-024 On RSTN low: RES_VALID=0, RES_P=0, stage-1 valid=0, stage-1 operands=0, STALL_CNT=0, and PTR=N_REQ-1 (requester 0 has first priority).
REQ-025 Reset mid-operation SHALL discard in-flight operations: no RES_VALID pulse for any accept made before reset.
REQ-026 REQ_READY SHALL be 0 while RSTN is low.

Configuration
REQ-027 When macro MULT_ARB_STALL_CNT_EN is defined, STALL_CNT SHALL increment by 1 on each cycle in which at least one requester has REQ_VALID=1 and REQ_READY=0, saturating at 16'hFFFF.
REQ-028 When MULT_ARB_STALL_CNT_EN is undefined, STALL_CNT SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-029 After reset, REQ_VALID=4'b0001 with A0=8'd200, B0=8'd255 for one cycle -> REQ_READY=4'b0001 that cycle; 2 cycles later RES_VALID=4'b0001 and RES_P=16'd51000.
REQ-030 REQ_VALID=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3 in order; results follow 2 cycles later with matching one-hot tags; STALL_CNT=8 (macro defined).
REQ-031 Only requester 2 valid for 5 consecutive cycles with A=B=k (k=1..5) -> 5 back-to-back RES_VALID=4'b0100 pulses, RES_P=1,4,9,16,25.
REQ-032 PTR=3 (last grant to requester 3), then REQ_VALID=4'b1001 -> requester 0 wins (wrap-around); next cycle requester 3 wins.
REQ-033 Accept at cycle t, RSTN pulsed low at t+1 -> no RES_VALID at t+2; outputs 0; the next grant goes to requester 0.
REQ-034 Build without MULT_ARB_STALL_CNT_EN and repeat REQ-030 -> STALL_CNT=0 throughout; all other results identical.
